// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Turns bytes from uart_rx into gate-enable commands (on / off / toggle).
// Drives the local enable and answers each byte with an echo or NACK
// through uart_tx. A watchdog forces the enable off when the link goes
// quiet while the gate is on.

module uart_cmd_decoder #(
    parameter logic [7:0]  CMD_ON      = 8'hEE,
    parameter logic [7:0]  CMD_OFF     = 8'h55,
    parameter logic [7:0]  CMD_TOGGLE  = 8'hC3,
    parameter logic [7:0]  NACK        = 8'hFF,
    parameter int unsigned WDT_CYCLES  = 48000000,
    parameter int unsigned REQ_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_received,
    input  logic        rx_done,
    input  logic        parity_error,
    input  logic        tx_busy,
    output logic [7:0]  data_to_tx,
    output logic        start_tx,
    output logic        out_enable,
    output logic        wdt_trip,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count
);

    // Counter widths: $clog2(N) bits are enough to hold N-1.
    localparam int unsigned WDT_W = ($clog2(WDT_CYCLES) > 0) ? $clog2(WDT_CYCLES) : 1;
    localparam int unsigned REQ_W = ($clog2(REQ_TIMEOUT) > 0) ? $clog2(REQ_TIMEOUT) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUSY
    } state_t;

    state_t           r_state;
    logic [REQ_W-1:0] r_req_cnt;
    logic [WDT_W-1:0] r_wdt_cnt;
    logic [7:0]       r_data_to_tx;
    logic             r_start_tx;
    logic             r_out_enable;
    logic             r_wdt_trip;
    logic [15:0]      r_cmd_count;
    logic [7:0]       r_err_count;

    logic             w_is_cmd;
    logic             w_valid;
    logic             w_error;
    logic [7:0]       w_reply;

    assign data_to_tx = r_data_to_tx;
    assign start_tx   = r_start_tx;
    assign out_enable = r_out_enable;
    assign wdt_trip   = r_wdt_trip;
    assign cmd_count  = r_cmd_count;
    assign err_count  = r_err_count;

    // Classify the byte offered this cycle and pick its reply.
    always_comb begin
        w_is_cmd = (data_received == CMD_ON) ||
                   (data_received == CMD_OFF) ||
                   (data_received == CMD_TOGGLE);
        w_valid  = rx_done && !parity_error && w_is_cmd;
        w_error  = rx_done && !w_valid;
        w_reply  = w_valid ? data_received : NACK;
    end

    // Gate enable and watchdog; a valid command in the trip cycle takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_enable <= 1'b0;
            r_wdt_trip   <= 1'b0;
            r_wdt_cnt    <= '0;
        end else if (w_valid) begin
            r_wdt_cnt <= '0;
            if (data_received == CMD_ON) begin
                r_out_enable <= 1'b1;
                r_wdt_trip   <= 1'b0;
            end else if (data_received == CMD_OFF) begin
                r_out_enable <= 1'b0;
            end else begin
                r_out_enable <= ~r_out_enable;
            end
        end else if (r_out_enable) begin
            if (r_wdt_cnt == WDT_LAST) begin
                r_out_enable <= 1'b0;
                r_wdt_trip   <= 1'b1;
                r_wdt_cnt    <= '0;
            end else begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
        end else begin
            r_wdt_cnt <= '0;
        end
    end

    // Saturating command and error counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_count <= '0;
            r_err_count <= '0;
        end else begin
            if (w_valid && (r_cmd_count != '1)) begin
                r_cmd_count <= r_cmd_count + 16'd1;
            end
            if (w_error && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Reply handshake with uart_tx; bytes arriving outside IDLE get no reply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_cnt    <= '0;
            r_data_to_tx <= '0;
            r_start_tx   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_req_cnt <= '0;
                    if (rx_done) begin
                        r_data_to_tx <= w_reply;
                        r_start_tx   <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tx_busy) begin
                        r_start_tx <= 1'b0;
                        r_state    <= S_BUSY;
                    end else if (r_req_cnt == REQ_LAST) begin
                        r_start_tx <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_start_tx <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
